// File: rtl/wbgpio_irq.sv
// wbgpio_irq: Wishbone GPIO with per-pin direction, set/clear, 2-FF sync and W1C edge interrupts.
// Define GPIO_DEBOUNCE_EN to add a per-pin DEBOUNCE_CYC stability filter on the inputs.
module wbgpio_irq #(
  parameter int NIO = 8,
  parameter logic [NIO-1:0] DEFAULT_OUT = '0,
  parameter logic [NIO-1:0] DEFAULT_DIR = '0,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic           i_wb_cyc,
  input  logic           i_wb_stb,
  input  logic           i_wb_we,
  input  logic [2:0]     i_wb_addr,
  input  logic [31:0]    i_wb_data,
  output logic           o_wb_ack,
  output logic           o_wb_stall,
  output logic [31:0]    o_wb_data,
  input  logic [NIO-1:0] i_gpio,
  output logic [NIO-1:0] o_gpio,
  output logic [NIO-1:0] o_gpio_oe,
  output logic           o_int
);
  logic [NIO-1:0] out_q, out_d, dir_q, dir_d, ren_q, ren_d, fen_q, fen_d, pend_q, pend_d;
  logic [NIO-1:0] s1_q, s2_q, filt_q, filt_d, prev_q;
  logic [NIO-1:0] wd, rv, w1c, rise, fall;
  logic [31:0] rd_q, rd_d;
  logic ack_q, int_q, acc, wr;
  logic unused_wd;
  assign unused_wd = ^i_wb_data;
  always_comb begin
    acc = i_wb_cyc & i_wb_stb;
    wr = acc & i_wb_we;
    wd = i_wb_data[NIO-1:0];
    out_d = (wr && i_wb_addr == 3'd1) ? wd :
            (wr && i_wb_addr == 3'd2) ? out_q | wd :
            (wr && i_wb_addr == 3'd3) ? out_q & ~wd : out_q;
    dir_d = (wr && i_wb_addr == 3'd4) ? wd : dir_q;
    ren_d = (wr && i_wb_addr == 3'd5) ? wd : ren_q;
    fen_d = (wr && i_wb_addr == 3'd6) ? wd : fen_q;
    w1c = (wr && i_wb_addr == 3'd7) ? wd : '0;
    rise = filt_q & ~prev_q;
    fall = prev_q & ~filt_q;
    // a fresh edge is ORed in after the clear so it is never lost to a racing W1C
    pend_d = (pend_q & ~w1c) | (rise & ren_q) | (fall & fen_q);
    rv = (i_wb_addr == 3'd0) ? filt_q :
         (i_wb_addr == 3'd1) ? out_q :
         (i_wb_addr == 3'd4) ? dir_q :
         (i_wb_addr == 3'd5) ? ren_q :
         (i_wb_addr == 3'd6) ? fen_q :
         (i_wb_addr == 3'd7) ? pend_q : '0;
    rd_d = '0;
    rd_d[NIO-1:0] = rv;
  end
`ifdef GPIO_DEBOUNCE_EN
  logic [NIO-1:0][15:0] cnt_q, cnt_d;
  always_comb begin
    filt_d = filt_q;
    cnt_d = cnt_q;
    for (int k = 0; k < NIO; k++) begin
      cnt_d[k] = (s2_q[k] == filt_q[k]) ? 16'd0 : cnt_q[k] + 16'd1;
      if (s2_q[k] != filt_q[k] && cnt_q[k] == 16'(DEBOUNCE_CYC - 1)) begin
        filt_d[k] = s2_q[k];
        cnt_d[k] = 16'd0;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign filt_d = s2_q;
`endif
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_q <= DEFAULT_OUT;
      dir_q <= DEFAULT_DIR;
      ren_q <= '0;
      fen_q <= '0;
      pend_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      filt_q <= '0;
      prev_q <= '0;
      ack_q <= 1'b0;
      rd_q <= '0;
      int_q <= 1'b0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
      ren_q <= ren_d;
      fen_q <= fen_d;
      pend_q <= pend_d;
      s1_q <= i_gpio;
      s2_q <= s1_q;
      filt_q <= filt_d;
      prev_q <= filt_q;
      ack_q <= acc;
      rd_q <= acc ? rd_d : rd_q;
      int_q <= |(pend_q & (ren_q | fen_q));
    end
  end
  assign o_wb_ack = ack_q;
  assign o_wb_stall = 1'b0;
  assign o_wb_data = rd_q;
  assign o_gpio = out_q;
  assign o_gpio_oe = dir_q;
  assign o_int = int_q;
endmodule
